// File: rtl/display_timings.sv
// Raster timing generator: pixel position, sync, blanking and frame/line strobes, all registered.
// Optional macro DISPLAY_TIMINGS_LOOKAHEAD_EN adds sx_next/sy_next (position one cycle ahead).
module display_timings #(
  parameter int CORDW  = 11,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line,
  output logic [15:0]      frame_cnt
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
  ,
  output logic [CORDW-1:0] sx_next,
  output logic [CORDW-1:0] sy_next
`endif
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << CORDW) || V_TOTAL > (1 << CORDW)) begin : g_width_check
    $error("display_timings: H_TOTAL/V_TOTAL do not fit in CORDW bits");
  end

  localparam logic [CORDW-1:0] ONE    = CORDW'(1);
  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);

  logic [CORDW-1:0] r_sx, r_sy;
  logic             r_hs, r_vs, r_de, r_frame, r_line;
  logic [15:0]      r_frame_cnt;
  logic [CORDW-1:0] w_sx_n, w_sy_n;

  // Every output is decoded from the next position so all of them land
  // together on the same edge as the coordinates.
  always_comb begin
    w_sx_n = r_sx + ONE;
    w_sy_n = r_sy;
    if (r_sx == H_LAST) begin
      w_sx_n = '0;
      w_sy_n = (r_sy == V_LAST) ? '0 : r_sy + ONE;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_sx        <= H_LAST;
      r_sy        <= V_LAST;
      r_de        <= 1'b0;
      r_hs        <= ~H_POL;
      r_vs        <= ~V_POL;
      r_frame     <= 1'b0;
      r_line      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_sx    <= w_sx_n;
      r_sy    <= w_sy_n;
      r_de    <= (w_sx_n < H_ACT) && (w_sy_n < V_ACT);
      r_hs    <= (w_sx_n >= HS_BEG && w_sx_n <= HS_END) ? H_POL : ~H_POL;
      r_vs    <= (w_sy_n >= VS_BEG && w_sy_n <= VS_END) ? V_POL : ~V_POL;
      r_line  <= (w_sx_n == '0);
      r_frame <= (w_sx_n == '0) && (w_sy_n == '0);
      if (w_sx_n == '0 && w_sy_n == '0) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign sx        = r_sx;
  assign sy        = r_sy;
  assign de        = r_de;
  assign hsync     = r_hs;
  assign vsync     = r_vs;
  assign frame     = r_frame;
  assign line      = r_line;
  assign frame_cnt = r_frame_cnt;

`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
  logic [CORDW-1:0] r_sx_next, r_sy_next;
  logic [CORDW-1:0] w_sx_nn, w_sy_nn;

  // Second step ahead, registered so sx_next tracks the next cycle's sx.
  always_comb begin
    w_sx_nn = w_sx_n + ONE;
    w_sy_nn = w_sy_n;
    if (w_sx_n == H_LAST) begin
      w_sx_nn = '0;
      w_sy_nn = (w_sy_n == V_LAST) ? '0 : w_sy_n + ONE;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_sx_next <= '0;
      r_sy_next <= '0;
    end else begin
      r_sx_next <= w_sx_nn;
      r_sy_next <= w_sy_nn;
    end
  end

  assign sx_next = r_sx_next;
  assign sy_next = r_sy_next;
`endif

endmodule

// File: tb/tb_display_timings.sv
// Directed bench: default 640x480 DUT for line timing, small inverted-polarity DUT for frame/reset.
module tb_display_timings;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [10:0] sx_a, sy_a;
  logic        hs_a, vs_a, de_a, fr_a, ln_a;
  logic [15:0] fc_a;
  logic [5:0]  sx_b, sy_b;
  logic        hs_b, vs_b, de_b, fr_b, ln_b;
  logic [15:0] fc_b;
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
  logic [10:0] sxn_a, syn_a;
  logic [5:0]  sxn_b, syn_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  display_timings u_a (
    .clk_pix(clk), .rst_pix(rst_a), .sx(sx_a), .sy(sy_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .frame(fr_a), .line(ln_a),
    .frame_cnt(fc_a)
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
    , .sx_next(sxn_a), .sy_next(syn_a)
`endif
  );

  // 15 x 8 raster: hsync sx 10..12, vsync sy 5..6, active 8x4, 120 cycles/frame
  display_timings #(
    .CORDW(6), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
  ) u_b (
    .clk_pix(clk), .rst_pix(rst_b), .sx(sx_b), .sy(sy_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .frame(fr_b), .line(ln_b),
    .frame_cnt(fc_b)
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
    , .sx_next(sxn_b), .sy_next(syn_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (sx_a !== 11'd799 || sy_a !== 11'd524 || de_a !== 1'b0 || hs_a !== 1'b1 ||
        vs_a !== 1'b1 || fr_a !== 1'b0 || ln_a !== 1'b0 || fc_a !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_a: got sx=%0d sy=%0d de=%b hs=%b vs=%b fr=%b ln=%b fc=%0d, want 799 524 0 1 1 0 0 0",
               sx_a, sy_a, de_a, hs_a, vs_a, fr_a, ln_a, fc_a);
    end
    n_cmp++;
    if (sx_b !== 6'd14 || sy_b !== 6'd7 || de_b !== 1'b0 || hs_b !== 1'b0 ||
        vs_b !== 1'b0 || fr_b !== 1'b0 || ln_b !== 1'b0 || fc_b !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_b: got sx=%0d sy=%0d de=%b hs=%b vs=%b fr=%b ln=%b fc=%0d, want 14 7 0 0 0 0 0 0",
               sx_b, sy_b, de_b, hs_b, vs_b, fr_b, ln_b, fc_b);
    end
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
    n_cmp++;
    if (sxn_a !== 11'd0 || syn_a !== 11'd0 || sxn_b !== 6'd0 || syn_b !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_next: got a=(%0d,%0d) b=(%0d,%0d), want all 0", sxn_a, syn_a, sxn_b, syn_b);
    end
`endif
  endtask

  task automatic test_release();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    n_cmp++;
    if (sx_a !== 11'd0 || sy_a !== 11'd0 || de_a !== 1'b1 || fr_a !== 1'b1 ||
        ln_a !== 1'b1 || fc_a !== 16'd1 || hs_a !== 1'b1 || vs_a !== 1'b1) begin
      n_bad++;
      $display("FAIL release_a: got sx=%0d sy=%0d de=%b fr=%b ln=%b fc=%0d hs=%b vs=%b, want 0 0 1 1 1 1 1 1",
               sx_a, sy_a, de_a, fr_a, ln_a, fc_a, hs_a, vs_a);
    end
    n_cmp++;
    if (sx_b !== 6'd0 || sy_b !== 6'd0 || de_b !== 1'b1 || fr_b !== 1'b1 ||
        ln_b !== 1'b1 || fc_b !== 16'd1) begin
      n_bad++;
      $display("FAIL release_b: got sx=%0d sy=%0d de=%b fr=%b ln=%b fc=%0d, want 0 0 1 1 1 1",
               sx_b, sy_b, de_b, fr_b, ln_b, fc_b);
    end
  endtask

  // Default DUT is at (0,0); walk one full 800-pixel line.
  task automatic test_line();
    int hs_cnt = 0;
    int hs_first = -1;
    int hs_last = -1;
    logic exp_de, exp_hs;
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
    logic [10:0] nx;
`endif
    for (int i = 0; i < 800; i++) begin
      exp_de = (i < 640);
      exp_hs = !(i >= 656 && i <= 751);
      n_cmp++;
      if (sx_a !== 11'(i) || sy_a !== 11'd0 || de_a !== exp_de || hs_a !== exp_hs ||
          vs_a !== 1'b1 || ln_a !== (i == 0) || fr_a !== (i == 0)) begin
        n_bad++;
        $display("FAIL line_step %0d: got sx=%0d sy=%0d de=%b hs=%b vs=%b ln=%b fr=%b, want %0d 0 %b %b 1 %b %b",
                 i, sx_a, sy_a, de_a, hs_a, vs_a, ln_a, fr_a, i, exp_de, exp_hs, i == 0, i == 0);
      end
      if (hs_a === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
      nx = sxn_a;
`endif
      tick();
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
      n_cmp++;
      if (sx_a !== nx) begin
        n_bad++;
        $display("FAIL sx_next_a at %0d: prior sx_next=%0d, sx now=%0d", i, nx, sx_a);
      end
`endif
    end
    n_cmp++;
    if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
      n_bad++;
      $display("FAIL hsync_window: got %0d cycles %0d..%0d, want 96 cycles 656..751", hs_cnt, hs_first, hs_last);
    end
    n_cmp++;
    if (sx_a !== 11'd0 || sy_a !== 11'd1 || ln_a !== 1'b1 || fr_a !== 1'b0 || de_a !== 1'b1 || fc_a !== 16'd1) begin
      n_bad++;
      $display("FAIL line_wrap: got sx=%0d sy=%0d ln=%b fr=%b de=%b fc=%0d, want 0 1 1 0 1 1",
               sx_a, sy_a, ln_a, fr_a, de_a, fc_a);
    end
  endtask

  // Small DUT: reset-align, then walk a full 120-cycle frame.
  task automatic test_frame();
    int vs_cnt = 0;
    int ex, ey;
    logic exp_de, exp_hs, exp_vs;
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
    logic [5:0] nx, ny;
`endif
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    tick();
    for (int i = 0; i < 120; i++) begin
      ex = i % 15;
      ey = i / 15;
      exp_de = (ex < 8) && (ey < 4);
      exp_hs = (ex >= 10 && ex <= 12);
      exp_vs = (ey >= 5 && ey <= 6);
      n_cmp++;
      if (sx_b !== 6'(ex) || sy_b !== 6'(ey) || de_b !== exp_de || hs_b !== exp_hs ||
          vs_b !== exp_vs || ln_b !== (ex == 0) || fr_b !== (i == 0) || fc_b !== 16'd1) begin
        n_bad++;
        $display("FAIL frame_step %0d: got sx=%0d sy=%0d de=%b hs=%b vs=%b ln=%b fr=%b fc=%0d, want %0d %0d %b %b %b %b %b 1",
                 i, sx_b, sy_b, de_b, hs_b, vs_b, ln_b, fr_b, fc_b, ex, ey, exp_de, exp_hs, exp_vs, ex == 0, i == 0);
      end
      if (vs_b === 1'b1) vs_cnt++;
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
      nx = sxn_b;
      ny = syn_b;
      if (i == 119) begin
        n_cmp++;
        if (nx !== 6'd0 || ny !== 6'd0) begin
          n_bad++;
          $display("FAIL next_wrap_b: got (%0d,%0d), want (0,0)", nx, ny);
        end
      end
`endif
      tick();
`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
      n_cmp++;
      if (sx_b !== nx || sy_b !== ny) begin
        n_bad++;
        $display("FAIL next_b at %0d: prior next=(%0d,%0d), now=(%0d,%0d)", i, nx, ny, sx_b, sy_b);
      end
`endif
    end
    n_cmp++;
    if (vs_cnt != 30) begin
      n_bad++;
      $display("FAIL vsync_cycles: got %0d, want 30", vs_cnt);
    end
    n_cmp++;
    if (sx_b !== 6'd0 || sy_b !== 6'd0 || fr_b !== 1'b1 || ln_b !== 1'b1 || fc_b !== 16'd2) begin
      n_bad++;
      $display("FAIL frame_wrap: got sx=%0d sy=%0d fr=%b ln=%b fc=%0d, want 0 0 1 1 2",
               sx_b, sy_b, fr_b, ln_b, fc_b);
    end
  endtask

  // Small DUT at (0,0) of frame 2; go to (5,3), pulse reset for one cycle.
  task automatic test_midreset();
    repeat (50) tick();
    n_cmp++;
    if (sx_b !== 6'd5 || sy_b !== 6'd3 || fc_b !== 16'd2) begin
      n_bad++;
      $display("FAIL midreset_pos: got sx=%0d sy=%0d fc=%0d, want 5 3 2", sx_b, sy_b, fc_b);
    end
    rst_b = 1'b1;
    tick();
    n_cmp++;
    if (sx_b !== 6'd14 || sy_b !== 6'd7 || de_b !== 1'b0 || hs_b !== 1'b0 ||
        vs_b !== 1'b0 || fr_b !== 1'b0 || ln_b !== 1'b0 || fc_b !== 16'd0) begin
      n_bad++;
      $display("FAIL midreset_hold: got sx=%0d sy=%0d de=%b hs=%b vs=%b fr=%b ln=%b fc=%0d, want 14 7 0 0 0 0 0 0",
               sx_b, sy_b, de_b, hs_b, vs_b, fr_b, ln_b, fc_b);
    end
    rst_b = 1'b0;
    tick();
    n_cmp++;
    if (sx_b !== 6'd0 || sy_b !== 6'd0 || de_b !== 1'b1 || fr_b !== 1'b1 ||
        ln_b !== 1'b1 || fc_b !== 16'd1) begin
      n_bad++;
      $display("FAIL midreset_release: got sx=%0d sy=%0d de=%b fr=%b ln=%b fc=%0d, want 0 0 1 1 1 1",
               sx_b, sy_b, de_b, fr_b, ln_b, fc_b);
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_line();
    test_frame();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_timings.md
DISPLAY_TIMINGS -- requirements
Module: display_timings

Interface
REQ-001 SHALL have parameter CORDW, default 11, coordinate width in bits.
REQ-002 SHALL have parameter H_RES, default 640, active pixels per line.
REQ-003 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal front porch, sync and back porch in pixels.
REQ-004 SHALL have parameter V_RES, default 480, active lines per frame.
REQ-005 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical front porch, sync and back porch in lines.
REQ-006 SHALL have parameters H_POL and V_POL, default 0 each, sync active level (0 = active-low).
REQ-007 SHALL have port clk_pix, input, 1, pixel clock; the block's only clock.
REQ-008 SHALL have port rst_pix, input, 1, reset; synchronous to clk_pix and active-high.
REQ-009 SHALL have port sx, output, CORDW, horizontal position.
REQ-010 SHALL have port sy, output, CORDW, vertical position.
REQ-011 SHALL have ports hsync and vsync, output, 1 each, sync pulses at H_POL/V_POL level.
REQ-012 SHALL have port de, output, 1, high inside the active area.
REQ-013 SHALL have ports frame and line, output, 1 each, start-of-frame and start-of-line strobes.
REQ-014 SHALL have port frame_cnt, output, 16, count of frames started since reset.

Function
REQ-015 SHALL define H_TOTAL = H_RES+H_FP+H_SYNC+H_BP and V_TOTAL = V_RES+V_FP+V_SYNC+V_BP; both SHALL fit in CORDW bits, enforced by an elaboration-time error.
REQ-016 SHALL advance sx by 1 every clk_pix cycle out of reset; at H_TOTAL-1, sx SHALL wrap to 0 and sy SHALL advance by 1.
REQ-017 SHALL wrap sy from V_TOTAL-1 to 0 in the same cycle that sx wraps.
REQ-018 SHALL assert de iff sx < H_RES and sy < V_RES.
REQ-019 SHALL drive hsync active iff H_RES+H_FP <= sx <= H_RES+H_FP+H_SYNC-1; it SHALL be inactive otherwise.
REQ-020 SHALL drive vsync active iff V_RES+V_FP <= sy <= V_RES+V_FP+V_SYNC-1, for whole lines, independent of sx.
REQ-021 SHALL pulse line high for one cycle when sx==0, on every line including blanking lines.
REQ-022 SHALL pulse frame high for one cycle when sx==0 and sy==0.
REQ-023 SHALL increment frame_cnt in the same cycle frame is high; frame_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-024 SHALL register every output; all outputs SHALL describe the same (sx,sy) position in the same cycle, with zero skew between them.

Reset
REQ-025 While rst_pix is high, outputs SHALL be sx=H_TOTAL-1, sy=V_TOTAL-1, de=0, hsync and vsync inactive, frame=0, line=0, frame_cnt=0.
REQ-026 In the first cycle after rst_pix falls, outputs SHALL be sx=0, sy=0, de=1, line=1, frame=1, frame_cnt=1.
REQ-027 Reset asserted mid-frame SHALL take effect at the next clk_pix edge, with no partial line or frame completed.

Configuration
REQ-028 With macro DISPLAY_TIMINGS_LOOKAHEAD_EN defined, the block SHALL add outputs sx_next and sy_next, width CORDW each, giving the position one cycle ahead of sx/sy (including wrap), for upstream fetch stages; during reset they SHALL be 0,0.
REQ-029 Without DISPLAY_TIMINGS_LOOKAHEAD_EN, the ports sx_next and sy_next and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Default parameters, release reset -> first cycle shows sx=0, sy=0, de=1, frame=1, line=1, frame_cnt=1.
REQ-031 Run one line -> de falls at sx=640; hsync is low for exactly sx 656..751 (96 cycles); sx wraps 799->0 with sy 0->1 and line=1.
REQ-032 Run one full frame -> exactly 800*525=420000 cycles between frame pulses; vsync is low for exactly sy 490..491; de never high for sy>=480.
REQ-033 H_POL=1, V_POL=1 -> hsync and vsync are high during the same windows as REQ-031/REQ-032 and low elsewhere.
REQ-034 Assert rst_pix at sx=300, sy=200 for 1 cycle -> outputs match REQ-025 during reset; the next cycle matches REQ-026 with frame_cnt=1.
REQ-035 With DISPLAY_TIMINGS_LOOKAHEAD_EN, at sx=799, sy=524 -> sx_next=0, sy_next=0; at every cycle, sx_next equals the sx of the following cycle.
